// File: rtl/output_display_if.sv
// output_display_if -- bus between the CPU output register and the display block.
//   data        : byte presented by the CPU
//   load        : output-register-in strobe, samples data/signed_mode
//   signed_mode : interpret data as two's complement
//   value       : last captured byte
//   busy        : binary-to-BCD conversion in progress
//   seg         : active-high segments, seg[0]=a .. seg[6]=g
//   digit_en    : one-hot digit select (3 sign, 2 hundreds, 1 tens, 0 ones)
interface output_display_if;
   logic [7:0] data;
   logic       load;
   logic       signed_mode;
   logic [7:0] value;
   logic       busy;
   logic [6:0] seg;
   logic [3:0] digit_en;

   modport master (
      output data, load, signed_mode,
      input  value, busy, seg, digit_en
   );

   modport slave (
      input  data, load, signed_mode,
      output value, busy, seg, digit_en
   );
endinterface

// File: rtl/output_display.sv
// output_display -- captures a CPU output byte, converts it to decimal with a
// serial double-dabble engine and multiplexes it onto a 4-digit 7-segment
// display (sign, hundreds, tens, ones).
// Ports:
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous active-low reset
//   bus : output_display_if.slave (data/load/signed_mode in;
//         value/busy/seg/digit_en out)
// Parameter:
//   SCAN_DIV : clk cycles per digit scan slot (1..65535)
module output_display #(
   parameter int unsigned SCAN_DIV = 1024
) (
   input  logic           clk,
   input  logic           rst,
   output_display_if.slave bus
);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t      state_q, state_d;
   logic [7:0]  value_q, value_d;
   logic        neg_q, neg_d;
   logic [7:0]  mag_q, mag_d;
   logic [11:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [3:0]  disp_h_q, disp_h_d;
   logic [3:0]  disp_t_q, disp_t_d;
   logic [3:0]  disp_o_q, disp_o_d;
   logic        disp_neg_q, disp_neg_d;
   logic [15:0] scan_q, scan_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  digit_en_q;
   logic [6:0]  seg_q, seg_d;
   logic [7:0]  neg_mag;
   logic        data_neg;

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the
   // magnitude MSB into the BCD register.
   function automatic logic [19:0] dd_step(input logic [11:0] bcd,
                                           input logic [7:0]  mag);
      logic [11:0] adj;
      adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (adj[i*4 +: 4] >= 4'd5)
            adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end
      return {adj[10:0], mag[7], mag[6:0], 1'b0};
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'h3F;
         4'd1:    glyph = 7'h06;
         4'd2:    glyph = 7'h5B;
         4'd3:    glyph = 7'h4F;
         4'd4:    glyph = 7'h66;
         4'd5:    glyph = 7'h6D;
         4'd6:    glyph = 7'h7D;
         4'd7:    glyph = 7'h07;
         4'd8:    glyph = 7'h7F;
         4'd9:    glyph = 7'h6F;
         default: glyph = 7'h00;
      endcase
   endfunction

   // Glyph for one digit position, including sign and leading-zero blanking.
   function automatic logic [6:0] digit_seg(input logic [1:0] idx,
                                            input logic [3:0] h,
                                            input logic [3:0] t,
                                            input logic [3:0] o,
                                            input logic       neg);
      case (idx)
         2'd3:    digit_seg = neg ? 7'h40 : 7'h00;
         2'd2:    digit_seg = (h == 4'd0) ? 7'h00 : glyph(h);
         2'd1:    digit_seg = (h == 4'd0 && t == 4'd0) ? 7'h00 : glyph(t);
         default: digit_seg = glyph(o);
      endcase
   endfunction

   // Two's-complement negate in 8 bits; 8'h80 maps to 128 which still fits.
   assign neg_mag  = ~bus.data + 8'd1;
   assign data_neg = bus.signed_mode & bus.data[7];

   always_comb begin
      state_d    = state_q;
      value_d    = value_q;
      neg_d      = neg_q;
      mag_d      = mag_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      disp_h_d   = disp_h_q;
      disp_t_d   = disp_t_q;
      disp_o_d   = disp_o_q;
      disp_neg_d = disp_neg_q;
      scan_d     = scan_q;
      idx_d      = idx_q;

      // A load always wins, restarting any conversion in flight.
      if (bus.load) begin
         value_d = bus.data;
         neg_d   = data_neg;
         mag_d   = data_neg ? neg_mag : bus.data;
         bcd_d   = '0;
         cnt_d   = '0;
         busy_d  = 1'b1;
         state_d = CONVERT;
      end else begin
         case (state_q)
            CONVERT: begin
               if (cnt_q != 4'd8) begin
                  {bcd_d, mag_d} = dd_step(bcd_q, mag_q);
                  cnt_d          = cnt_q + 4'd1;
               end else begin
                  // Display registers only change here, so partial
                  // results are never visible.
                  disp_h_d   = bcd_q[11:8];
                  disp_t_d   = bcd_q[7:4];
                  disp_o_d   = bcd_q[3:0];
                  disp_neg_d = neg_q;
                  busy_d     = 1'b0;
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (scan_q == 16'(SCAN_DIV - 1)) begin
         scan_d = '0;
         idx_d  = idx_q + 2'd1;
      end else begin
         scan_d = scan_q + 16'd1;
      end

      // Built from next-state values so seg and digit_en move together.
      seg_d = digit_seg(idx_d, disp_h_d, disp_t_d, disp_o_d, disp_neg_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         value_q    <= '0;
         neg_q      <= 1'b0;
         mag_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         disp_h_q   <= '0;
         disp_t_q   <= '0;
         disp_o_q   <= '0;
         disp_neg_q <= 1'b0;
         scan_q     <= '0;
         idx_q      <= '0;
         digit_en_q <= 4'b0001;
         seg_q      <= 7'h3F;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         neg_q      <= neg_d;
         mag_q      <= mag_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         disp_h_q   <= disp_h_d;
         disp_t_q   <= disp_t_d;
         disp_o_q   <= disp_o_d;
         disp_neg_q <= disp_neg_d;
         scan_q     <= scan_d;
         idx_q      <= idx_d;
         digit_en_q <= 4'b0001 << idx_d;
         seg_q      <= seg_d;
      end
   end

   assign bus.value    = value_q;
   assign bus.busy     = busy_q;
   assign bus.seg      = seg_q;
   assign bus.digit_en = digit_en_q;

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1024: clk cycles per digit scan slot; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port data, input, 8: CPU bus value to display.
REQ-005 SHALL have port load, input, 1: output-register-in strobe (oi); samples data on clk rising edge.
REQ-006 SHALL have port signed_mode, input, 1: when high, treat data as two's complement; sampled with load.
REQ-007 SHALL have port value, output, 8: last captured data byte.
REQ-008 SHALL have port busy, output, 1: binary-to-BCD conversion in progress.
REQ-009 SHALL have port seg, output, 7: active-high segments; seg[0]=a ... seg[6]=g.
REQ-010 SHALL have port digit_en, output, 4: one-hot, active-high digit select; bit 3 = sign, bit 2 = hundreds, bit 1 = tens, bit 0 = ones.

Function
REQ-011 SHALL implement states IDLE and CONVERT.
REQ-012 On a rising edge with load high (edge L), SHALL capture data into value, capture signed_mode, enter CONVERT, and set busy high; this holds in any state.
REQ-013 When load is high during CONVERT, SHALL abandon the current conversion and restart with the new byte (latest wins).
REQ-014 Captured magnitude SHALL be the byte itself, except when the captured signed_mode is 1 and data[7] is 1: magnitude = (~data + 1) in 9 bits, so 8'h80 gives 128, and a negative flag is set.
REQ-015 Conversion SHALL be shift-add-3 (double dabble): one magnitude bit per cycle, MSB first, over exactly 8 cycles, on edges L+1 through L+8.
REQ-016 On edge L+9, SHALL transfer hundreds/tens/ones/negative into the display registers, clear busy, and return to IDLE.
REQ-017 Display registers SHALL hold the previous result throughout CONVERT; no partial digits are ever shown.
REQ-018 Digit glyphs SHALL be 0..9 = 7'h3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F; minus = 7'h40; blank = 7'h00.
REQ-019 Sign digit SHALL show minus when negative is set, else blank.
REQ-020 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0; ones always shown.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-022 digit_en SHALL equal 1<<index; seg SHALL be the glyph for the selected digit, registered so seg and digit_en change on the same edge.
REQ-023 With SCAN_DIV=1, index SHALL advance every cycle.
REQ-024 Scan SHALL run continuously and independently of load/busy.

Reset
REQ-025 While rst is low: state IDLE, busy 0, value 8'h00, captured flags 0, shift registers 0, display registers = 0 (non-negative), scan counter 0, index 0, digit_en 4'b0001, seg 7'h3F.
REQ-026 Reset asserted mid-CONVERT SHALL discard the conversion; after release the display shows 0 until a new load completes.
REQ-027 First load SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-028 Unsigned: load data=8'd123, signed_mode=0 -> busy high for edges L..L+8, low after L+9; digits sign=blank, hundreds=7'h06, tens=7'h5B, ones=7'h4F.
REQ-029 Signed: load 8'hF6 -> sign=7'h40, hundreds blank, tens=7'h06, ones=7'h3F; load 8'h80 -> -128; load 8'hFF with signed_mode=0 -> 255, sign blank.
REQ-030 Blanking: load 8'd7 -> sign, hundreds and tens blank, ones=7'h07; load 8'd0 -> only ones=7'h3F.
REQ-031 Reload: load 8'd200, then load 8'd45 at L+4 -> display never shows 200, shows 45 at (second L)+9, and value=8'd45.
REQ-032 Reset mid-conversion: load 8'd99, assert rst at L+3 -> outputs at reset values immediately (async); after release the display shows 0.
REQ-033 Scan: SCAN_DIV=2 -> digit_en sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001..., with each seg matching the digit_en it appears with.
